// File: rtl/alu_mult_seq_if.sv
// Handshake and operand/result bundle for the sequential shift-add multiplier.
// Optional Signed control appears only when ALU_MULT_SIGNED_EN is defined.
interface alu_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Clear;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
`ifdef ALU_MULT_SIGNED_EN
  logic             Signed;
`endif
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result_Lo;
  logic [WIDTH-1:0] Result_Hi;

  modport master (
`ifdef ALU_MULT_SIGNED_EN
    output Signed,
`endif
    output Start, Clear, A, B,
    input  Busy, Done, Result_Lo, Result_Hi
  );

  modport slave (
`ifdef ALU_MULT_SIGNED_EN
    input  Signed,
`endif
    input  Start, Clear, A, B,
    output Busy, Done, Result_Lo, Result_Hi
  );
endinterface

// File: rtl/alu_mult_seq.sv
// Iterative shift-add multiplier, one partial product per cycle, feeding the ALU MULT slot and HI path.
// Define ALU_MULT_SIGNED_EN to add the Signed input (two's-complement operands).
//
// state  | meaning
// S_IDLE | waiting for Start; operands latched on Start
// S_RUN  | one add/shift step per cycle, cnt counts down from WIDTH
// S_DONE | single cycle, Done=1, results valid
module alu_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          Clk,
  input  logic          Rst_n,
  alu_mult_seq_if.slave bus
);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH:0]   add_sum;
  logic [PW-1:0]    acc_step;
  logic [PW-1:0]    product;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             last_step;

`ifdef ALU_MULT_SIGNED_EN
  logic neg_q;

  // Magnitude of 0x80..0 wraps to itself, which read unsigned is exactly 2^(WIDTH-1).
  always_comb begin
    a_mag = bus.A;
    b_mag = bus.B;
    if (bus.Signed && bus.A[WIDTH-1]) a_mag = ~bus.A + WIDTH'(1);
    if (bus.Signed && bus.B[WIDTH-1]) b_mag = ~bus.B + WIDTH'(1);
  end
`else
  always_comb begin
    a_mag = bus.A;
    b_mag = bus.B;
  end
`endif

  always_comb begin
    add_sum  = {1'b0, acc[PW-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_step = {add_sum, acc[WIDTH-1:1]};
`ifdef ALU_MULT_SIGNED_EN
    product  = neg_q ? (~acc_step + PW'(1)) : acc_step;
`else
    product  = acc_step;
`endif
  end

  assign last_step = (cnt == CNT_W'(1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.Start) state_nxt = S_RUN;
      S_RUN:   if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.Clear) state_nxt = S_IDLE;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      res_lo <= '0;
      res_hi <= '0;
`ifdef ALU_MULT_SIGNED_EN
      neg_q  <= 1'b0;
`endif
    end else if (!bus.Clear) begin
      if (state == S_IDLE && bus.Start) begin
        mcand  <= a_mag;
        mplier <= b_mag;
        acc    <= '0;
        cnt    <= CNT_W'(WIDTH);
`ifdef ALU_MULT_SIGNED_EN
        neg_q  <= bus.Signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
`endif
      end else if (state == S_RUN) begin
        acc    <= acc_step;
        mplier <= mplier >> 1;
        cnt    <= cnt - CNT_W'(1);
        // Results load on the RUN->DONE edge so they line up with Done.
        if (last_step) begin
          res_lo <= product[WIDTH-1:0];
          res_hi <= product[PW-1:WIDTH];
        end
      end
    end
  end

  assign bus.Busy      = (state == S_RUN) || (state == S_DONE);
  assign bus.Done      = (state == S_DONE);
  assign bus.Result_Lo = res_lo;
  assign bus.Result_Hi = res_hi;
endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed self-checking bench for alu_mult_seq; signed cases build only with ALU_MULT_SIGNED_EN.
module tb_alu_mult_seq;
  localparam int W = 32;

  logic Clk;
  logic Rst_n;
  int   n_tests;
  int   n_fail;

  alu_mult_seq_if #(.WIDTH(W)) bus ();

  alu_mult_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Issue one multiply and watch 36 cycles; cycle 1 is the one after the Start edge.
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int done_cyc, output int busy_cnt, output int done_cnt);
    done_cyc = 0;
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge Clk);
    bus.A = a;
    bus.B = b;
    bus.Start = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge Clk);
      if (c == 1) begin
        bus.Start = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
      end
      if (bus.Busy) busy_cnt++;
      if (bus.Done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    bus.Start = 1'b0;
    bus.Clear = 1'b0;
    bus.A = 32'h1234_5678;
    bus.B = 32'h9ABC_DEF0;
`ifdef ALU_MULT_SIGNED_EN
    bus.Signed = 1'b0;
`endif
    #12;
    n_tests++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
    n_tests++; if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.Done); end
    n_tests++; if (bus.Result_Lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.Result_Lo); end
    n_tests++; if (bus.Result_Hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.Result_Hi); end
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int dc, bc, nc;
    run_mult(32'd7, 32'd6, dc, bc, nc);
    n_tests++; if (dc != 33) begin n_fail++; $display("FAIL basic_latency got %0d want 33", dc); end
    n_tests++; if (bc != 33) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 33", bc); end
    n_tests++; if (nc != 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d want 1", nc); end
    n_tests++; if (bus.Result_Hi !== 32'h0) begin n_fail++; $display("FAIL basic_hi got %h want 00000000", bus.Result_Hi); end
    n_tests++; if (bus.Result_Lo !== 32'h2A) begin n_fail++; $display("FAIL basic_lo got %h want 0000002a", bus.Result_Lo); end
  endtask

  task automatic test_extremes();
    int dc, bc, nc;
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc, nc);
    n_tests++; if (bus.Result_Hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL max_hi got %h want fffffffe", bus.Result_Hi); end
    n_tests++; if (bus.Result_Lo !== 32'h0000_0001) begin n_fail++; $display("FAIL max_lo got %h want 00000001", bus.Result_Lo); end
    run_mult(32'h0, 32'h1234_5678, dc, bc, nc);
    n_tests++; if (dc != 33) begin n_fail++; $display("FAIL zero_latency got %0d want 33", dc); end
    n_tests++; if (bus.Result_Hi !== 32'h0) begin n_fail++; $display("FAIL zero_hi got %h want 0", bus.Result_Hi); end
    n_tests++; if (bus.Result_Lo !== 32'h0) begin n_fail++; $display("FAIL zero_lo got %h want 0", bus.Result_Lo); end
    run_mult(32'h8765_4321, 32'h0001_0000, dc, bc, nc);
    n_tests++; if ({bus.Result_Hi, bus.Result_Lo} !== 64'h0000_8765_4321_0000) begin
      n_fail++; $display("FAIL shift_prod got %h%h want 0000876543210000", bus.Result_Hi, bus.Result_Lo); end
  endtask

  task automatic test_back_to_back();
    int dc, bc, nc;
    dc = 0;
    @(negedge Clk);
    bus.A = 32'd3;
    bus.B = 32'd5;
    bus.Start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (c == 1) bus.Start = 1'b0;
      if (c == 10) begin bus.Start = 1'b1; bus.A = 32'd9; bus.B = 32'd9; end
      if (c == 11) bus.Start = 1'b0;
      if (bus.Done) begin dc = c; break; end
    end
    n_tests++; if (dc != 33) begin n_fail++; $display("FAIL ignored_start_latency got %0d want 33", dc); end
    n_tests++; if (bus.Result_Lo !== 32'h0000_000F) begin n_fail++; $display("FAIL ignored_start_lo got %h want 0000000f", bus.Result_Lo); end
    n_tests++; if (bus.Result_Hi !== 32'h0) begin n_fail++; $display("FAIL ignored_start_hi got %h want 0", bus.Result_Hi); end
    // Start raised in the IDLE cycle right after DONE.
    run_mult(32'd2, 32'd11, dc, bc, nc);
    n_tests++; if (dc != 33) begin n_fail++; $display("FAIL b2b_latency got %0d want 33", dc); end
    n_tests++; if (bus.Result_Lo !== 32'd22) begin n_fail++; $display("FAIL b2b_lo got %h want 00000016", bus.Result_Lo); end
  endtask

  task automatic test_clear();
    int nc;
    logic busy13;
    nc = 0;
    busy13 = 1'bx;
    @(negedge Clk);
    bus.A = 32'd100;
    bus.B = 32'd100;
    bus.Start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (c == 1) bus.Start = 1'b0;
      if (c == 12) bus.Clear = 1'b1;
      if (c == 13) begin busy13 = bus.Busy; bus.Clear = 1'b0; end
      if (bus.Done) nc++;
    end
    n_tests++; if (busy13 !== 1'b0) begin n_fail++; $display("FAIL clear_busy got %b want 0", busy13); end
    n_tests++; if (nc != 0) begin n_fail++; $display("FAIL clear_done_pulses got %0d want 0", nc); end
    n_tests++; if (bus.Result_Lo !== 32'd22) begin n_fail++; $display("FAIL clear_lo_kept got %h want 00000016", bus.Result_Lo); end
    // Clear beats Start in the same IDLE cycle.
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Clear = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.Clear = 1'b0;
    n_tests++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL clear_over_start got %b want 0", bus.Busy); end
  endtask

  task automatic test_reset_mid();
    int nc, bc, dc;
    nc = 0;
    bc = 0;
    @(negedge Clk);
    bus.A = 32'd100;
    bus.B = 32'd100;
    bus.Start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (c == 1) bus.Start = 1'b0;
      if (c == 12) begin
        Rst_n = 1'b0;
        #1;
        n_tests++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", bus.Busy); end
        n_tests++; if (bus.Result_Lo !== 32'h0) begin n_fail++; $display("FAIL rst_mid_lo got %h want 0", bus.Result_Lo); end
      end
      if (c == 13) Rst_n = 1'b1;
      if (c > 13) begin
        if (bus.Done) nc++;
        if (bus.Busy) bc++;
      end
    end
    n_tests++; if (nc != 0) begin n_fail++; $display("FAIL rst_mid_done_pulses got %0d want 0", nc); end
    n_tests++; if (bc != 0) begin n_fail++; $display("FAIL rst_mid_busy_after got %0d want 0", bc); end
    run_mult(32'd100, 32'd100, dc, bc, nc);
    n_tests++; if (bus.Result_Lo !== 32'h0000_2710) begin n_fail++; $display("FAIL post_rst_lo got %h want 00002710", bus.Result_Lo); end
  endtask

`ifdef ALU_MULT_SIGNED_EN
  task automatic test_signed();
    int dc, bc, nc;
    bus.Signed = 1'b1;
    run_mult(32'hFFFF_FFFD, 32'd5, dc, bc, nc);
    n_tests++; if (dc != 33) begin n_fail++; $display("FAIL signed_latency got %0d want 33", dc); end
    n_tests++; if ({bus.Result_Hi, bus.Result_Lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      n_fail++; $display("FAIL signed_neg3x5 got %h%h want fffffffffffffff1", bus.Result_Hi, bus.Result_Lo); end
    run_mult(32'h8000_0000, 32'h8000_0000, dc, bc, nc);
    n_tests++; if ({bus.Result_Hi, bus.Result_Lo} !== 64'h4000_0000_0000_0000) begin
      n_fail++; $display("FAIL signed_minmin got %h%h want 4000000000000000", bus.Result_Hi, bus.Result_Lo); end
    bus.Signed = 1'b0;
    run_mult(32'hFFFF_FFFD, 32'd5, dc, bc, nc);
    n_tests++; if ({bus.Result_Hi, bus.Result_Lo} !== 64'h0000_0004_FFFF_FFF1) begin
      n_fail++; $display("FAIL unsigned_fffd_x5 got %h%h want 00000004fffffff1", bus.Result_Hi, bus.Result_Lo); end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_clear();
    test_reset_mid();
`ifdef ALU_MULT_SIGNED_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
